fp_mul_arbiter: RTL and testbench

Round-robin arbiter that time-shares one IEEE-754 single-precision `multiplier` between `N_REQ` requesters. Geometry units such as the cross-product and dot-product engines use it to replace dedicated per-lane multipliers with one shared instance, trading latency for area. Each requester uses a stb/ack operand and result handshake. The arbiter sequences the multiplier's `input_a`/`input_b`/`output_z` handshakes and routes the product back to the requester that issued it.

---
 rtl/fp_arb_pkg.sv | 15 +
 rtl/rr_picker.sv | 33 +++
 rtl/fp_mul_arbiter.sv | 138 +++++++++++++
 tb/tb_fp_mul_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_arb_pkg.sv
// Shared types for the floating-point multiplier arbiter.
package fp_arb_pkg;

    localparam int FP_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SEND_A,
        SEND_B,
        WAIT_Z,
        RESP
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int GNT_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GNT_W-1:0] ptr,
    output logic             valid,
    output logic [GNT_W-1:0] idx
);

    // One extra bit so ptr+k never overflows before the modulo fold.
    localparam int SW = GNT_W + 1;

    logic [SW-1:0] pos;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = {1'b0, ptr} + SW'(k);
            if (pos >= SW'(N_REQ)) begin
                pos = pos - SW'(N_REQ);
            end
            if (!valid && req[pos[GNT_W-1:0]]) begin
                valid = 1'b1;
                idx   = pos[GNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Time-shares one stb/ack single-precision multiplier between N_REQ requesters.
module fp_mul_arbiter
    import fp_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int GNT_W = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_stb,
    input  logic [N_REQ*FP_W-1:0] req_a,
    input  logic [N_REQ*FP_W-1:0] req_b,
    output logic [N_REQ-1:0]      req_ack,
    output logic [FP_W-1:0]       resp_z,
    output logic [N_REQ-1:0]      resp_stb,
    input  logic [N_REQ-1:0]      resp_ack,
    output logic [FP_W-1:0]       mul_a,
    output logic                  mul_a_stb,
    input  logic                  mul_a_ack,
    output logic [FP_W-1:0]       mul_b,
    output logic                  mul_b_stb,
    input  logic                  mul_b_ack,
    input  logic [FP_W-1:0]       mul_z,
    input  logic                  mul_z_stb,
    output logic                  mul_z_ack,
    output logic                  busy,
    output logic [GNT_W-1:0]      gnt_id
);

    arb_state_t       state;
    logic [GNT_W-1:0] rr_ptr;
    logic [FP_W-1:0]  op_a;
    logic [FP_W-1:0]  op_b;
    logic [FP_W-1:0]  z_reg;
    logic             pick_valid;
    logic [GNT_W-1:0] pick_idx;

    function automatic logic [GNT_W-1:0] ptr_after(input logic [GNT_W-1:0] w);
        return (w == GNT_W'(N_REQ - 1)) ? '0 : w + GNT_W'(1);
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [GNT_W-1:0] i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    rr_picker #(
        .N_REQ(N_REQ),
        .GNT_W(GNT_W)
    ) u_picker (
        .req  (req_stb),
        .ptr  (rr_ptr),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    assign resp_z = z_reg;

    // Outputs are registered, so each is set on the edge that enters its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt_id    <= '0;
            req_ack   <= '0;
            resp_stb  <= '0;
            mul_a_stb <= 1'b0;
            mul_b_stb <= 1'b0;
            mul_z_ack <= 1'b0;
            busy      <= 1'b0;
            z_reg     <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state   <= GRANT;
                        gnt_id  <= pick_idx;
                        op_a    <= req_a[FP_W*pick_idx +: FP_W];
                        op_b    <= req_b[FP_W*pick_idx +: FP_W];
                        rr_ptr  <= ptr_after(pick_idx);
                        req_ack <= onehot(pick_idx);
                        busy    <= 1'b1;
                    end
                end
                GRANT: begin
                    req_ack   <= '0;
                    mul_a     <= op_a;
                    mul_a_stb <= 1'b1;
                    state     <= SEND_A;
                end
                SEND_A: begin
                    if (mul_a_stb && mul_a_ack) begin
                        mul_a_stb <= 1'b0;
                        mul_b     <= op_b;
                        mul_b_stb <= 1'b1;
                        state     <= SEND_B;
                    end
                end
                SEND_B: begin
                    if (mul_b_stb && mul_b_ack) begin
                        mul_b_stb <= 1'b0;
                        mul_z_ack <= 1'b1;
                        state     <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    if (mul_z_stb && mul_z_ack) begin
                        mul_z_ack <= 1'b0;
                        z_reg     <= mul_z;
                        resp_stb  <= onehot(gnt_id);
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ack[gnt_id]) begin
                        resp_stb <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ack   <= '0;
                    resp_stb  <= '0;
                    mul_a_stb <= 1'b0;
                    mul_b_stb <= 1'b0;
                    mul_z_ack <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a multiplier stand-in and a transaction-level model.
module tb_fp_mul_arbiter;

    localparam int N   = 4;
    localparam int GW  = 2;
    localparam int LAT = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_stb, req_ack, resp_stb, resp_ack;
    logic [N*32-1:0] req_a, req_b;
    logic [31:0]     resp_z, mul_a, mul_b, mul_z;
    logic            mul_a_stb, mul_a_ack, mul_b_stb, mul_b_ack;
    logic            mul_z_stb, mul_z_ack, busy;
    logic [GW-1:0]   gnt_id;

    int checks = 0;
    int errors = 0;

    fp_mul_arbiter #(.N_REQ(N), .GNT_W(GW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_stb  (req_stb),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_ack  (req_ack),
        .resp_z   (resp_z),
        .resp_stb (resp_stb),
        .resp_ack (resp_ack),
        .mul_a    (mul_a),
        .mul_a_stb(mul_a_stb),
        .mul_a_ack(mul_a_ack),
        .mul_b    (mul_b),
        .mul_b_stb(mul_b_stb),
        .mul_b_ack(mul_b_ack),
        .mul_z    (mul_z),
        .mul_z_stb(mul_z_stb),
        .mul_z_ack(mul_z_ack),
        .busy     (busy),
        .gnt_id   (gnt_id)
    );

    always #5 clk = ~clk;

    // Product of two normal floats, truncating; the bench only uses exact products.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] m;
        logic [23:0] mant;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        if (m[47]) begin
            mant = m[47:24];
            e    = e + 1;
        end else begin
            mant = m[46:23];
        end
        return {s, 8'(e), mant[22:0]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Multiplier stand-in: A ack after one wait cycle, B ack at once, result LAT cycles later.
    int          st = 0;
    int          sc = 0;
    logic [31:0] sa, sb;

    initial begin
        mul_a_ack = 1'b0;
        mul_b_ack = 1'b0;
        mul_z_stb = 1'b0;
        mul_z     = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                st = 0; sc = 0;
                mul_a_ack = 1'b0; mul_b_ack = 1'b0; mul_z_stb = 1'b0; mul_z = '0;
            end else begin
                mul_a_ack = (st == 0) && mul_a_stb && (sc > 0);
                mul_b_ack = (st == 1) && mul_b_stb;
                mul_z_stb = (st == 3);
                case (st)
                    0: if (mul_a_stb && mul_a_ack) begin sa = mul_a; st = 1; sc = 0; end
                       else if (mul_a_stb) sc++;
                    1: if (mul_b_stb && mul_b_ack) begin sb = mul_b; st = 2; sc = 0; end
                    2: begin
                        sc++;
                        if (sc >= LAT) begin mul_z = fmul(sa, sb); st = 3; end
                    end
                    default: if (mul_z_stb && mul_z_ack) begin st = 0; sc = 0; end
                endcase
            end
        end
    end

    // Requester side: acks, grant log and response log.
    logic [N-1:0] resp_hold;
    logic [N-1:0] drop_next;
    int           got_id[$];
    logic [31:0]  got_z[$];
    int           grants[$];

    task automatic tick();
        @(negedge clk);
        resp_ack  = ~resp_hold;
        req_stb   = req_stb & ~drop_next;
        drop_next = req_ack;
        for (int i = 0; i < N; i++) begin
            if (req_ack[i]) grants.push_back(i);
            if (resp_stb[i] && resp_ack[i]) begin
                got_id.push_back(i);
                got_z.push_back(resp_z);
            end
        end
    endtask

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_stb[i]        = 1'b1;
    endtask

    task automatic wait_got(input int n, input string nm);
        for (int k = 0; k < 400; k++) begin
            if (got_id.size() >= n) break;
            tick();
        end
        check(nm, 32'(got_id.size()), 32'(n));
    endtask

    task automatic expect_resp(input int id, input logic [31:0] z, input string nm);
        if (got_id.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: got no response expected id %0d z %h", nm, id, z);
        end else begin
            check({nm, "_id"}, 32'(got_id.pop_front()), 32'(id));
            check({nm, "_z"}, got_z.pop_front(), z);
        end
    endtask

    task automatic expect_grant(input int id, input string nm);
        if (grants.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: got no grant expected %0d", nm, id);
        end else begin
            check(nm, 32'(grants.pop_front()), 32'(id));
        end
    endtask

    task automatic check_reset_values(input string nm);
        check({nm, "_req_ack"}, 32'(req_ack), 32'd0);
        check({nm, "_resp_stb"}, 32'(resp_stb), 32'd0);
        check({nm, "_strobes"}, 32'({mul_a_stb, mul_b_stb, mul_z_ack}), 32'd0);
        check({nm, "_busy"}, 32'(busy), 32'd0);
        check({nm, "_resp_z"}, resp_z, 32'd0);
        check({nm, "_mul_a"}, mul_a, 32'd0);
        check({nm, "_mul_b"}, mul_b, 32'd0);
        check({nm, "_gnt_id"}, 32'(gnt_id), 32'd0);
    endtask

    // Transaction model: arbitrate on the idle cycle, grant the next, retire on resp handshake.
    logic         m_busy, m_grant_now;
    int           m_g, m_ptr, w, j;
    logic [31:0]  m_exp_z;
    logic [N-1:0] exp_vec;

    initial begin
        m_busy = 1'b0; m_grant_now = 1'b0; m_g = 0; m_ptr = 0; m_exp_z = '0;
        forever begin
            @(negedge clk);
            #2;
            exp_vec = '0;
            if (m_grant_now) exp_vec[m_g] = 1'b1;
            check("m_req_ack", 32'(req_ack), 32'(exp_vec));
            check("m_busy", 32'(busy), 32'(m_busy));
            if (m_grant_now) check("m_gnt_id", 32'(gnt_id), 32'(m_g));
            if (m_busy && resp_stb != '0) begin
                exp_vec = '0;
                exp_vec[m_g] = 1'b1;
                check("m_resp_stb", 32'(resp_stb), 32'(exp_vec));
                check("m_resp_z", resp_z, m_exp_z);
                check("m_resp_gnt", 32'(gnt_id), 32'(m_g));
            end
            if (!m_busy) check("m_idle_quiet", 32'({resp_stb, mul_a_stb, mul_b_stb, mul_z_ack}), 32'd0);
            if (rst) begin
                m_busy = 1'b0; m_grant_now = 1'b0; m_ptr = 0;
            end else if (!m_busy) begin
                m_grant_now = 1'b0;
                w = -1;
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (w < 0 && req_stb[j]) w = j;
                end
                if (w >= 0) begin
                    m_g = w; m_ptr = (w + 1) % N;
                    m_exp_z = fmul(req_a[32*w +: 32], req_b[32*w +: 32]);
                    m_busy = 1'b1; m_grant_now = 1'b1;
                end
            end else begin
                m_grant_now = 1'b0;
                if (resp_stb[m_g] && resp_ack[m_g]) m_busy = 1'b0;
            end
        end
    end

    // Protocol properties on every handshake port.
    a_mul_a_hold: assert property (@(posedge clk) disable iff (rst) (mul_a_stb && !mul_a_ack) |=> mul_a_stb)
        else begin errors++; $display("FAIL proto_mul_a_hold"); end
    a_mul_b_hold: assert property (@(posedge clk) disable iff (rst) (mul_b_stb && !mul_b_ack) |=> mul_b_stb)
        else begin errors++; $display("FAIL proto_mul_b_hold"); end
    a_mul_z_hold: assert property (@(posedge clk) disable iff (rst) (mul_z_stb && !mul_z_ack) |=> mul_z_stb)
        else begin errors++; $display("FAIL proto_mul_z_hold"); end
    a_resp_hold: assert property (@(posedge clk) disable iff (rst) ((resp_stb & ~resp_ack) != '0) |=> (resp_stb == $past(resp_stb)))
        else begin errors++; $display("FAIL proto_resp_hold"); end
    a_req_hold: assert property (@(posedge clk) disable iff (rst) ((req_stb & ~req_ack) != '0) |=> (($past(req_stb & ~req_ack) & ~req_stb) == '0))
        else begin errors++; $display("FAIL proto_req_hold"); end
    a_resp_onehot: assert property (@(posedge clk) $onehot0(resp_stb))
        else begin errors++; $display("FAIL proto_resp_onehot %b", resp_stb); end
    a_ack_onehot: assert property (@(posedge clk) $onehot0(req_ack))
        else begin errors++; $display("FAIL proto_ack_onehot %b", req_ack); end
    a_ack_pulse: assert property (@(posedge clk) disable iff (rst) (req_ack != '0) |=> (req_ack == '0))
        else begin errors++; $display("FAIL proto_ack_pulse"); end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_stb = '0; req_a = '0; req_b = '0;
        resp_ack = '0; resp_hold = '0; drop_next = '0;
        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // 2.0 * 3.0 from requester 0
        issue(0, 32'h40000000, 32'h40400000);
        wait_got(1, "single_done");
        expect_grant(0, "single_grant");
        expect_resp(0, 32'h40C00000, "single");
        check("single_gnt_id", 32'(gnt_id), 32'd0);
        check("single_one_ack", 32'(grants.size()), 32'd0);

        // 1.5 * -4.0 from requester 2
        tick();
        issue(2, 32'h3FC00000, 32'hC0800000);
        wait_got(1, "sign_done");
        expect_grant(2, "sign_grant");
        expect_resp(2, 32'hC0C00000, "sign");

        // all four at once, fresh from reset
        rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
        grants.delete(); got_id.delete(); got_z.delete();
        issue(0, 32'h3F800000, 32'h40000000);
        issue(1, 32'h40000000, 32'h40000000);
        issue(2, 32'h40400000, 32'h40400000);
        issue(3, 32'hC0000000, 32'h3F000000);
        wait_got(4, "all4_done");
        expect_grant(0, "all4_g0"); expect_grant(1, "all4_g1");
        expect_grant(2, "all4_g2"); expect_grant(3, "all4_g3");
        expect_resp(0, 32'h40000000, "all4_r0"); expect_resp(1, 32'h40800000, "all4_r1");
        expect_resp(2, 32'h41100000, "all4_r2"); expect_resp(3, 32'hBF800000, "all4_r3");

        // 3 and 1 together with the pointer back at 0
        tick();
        issue(3, 32'h3FC00000, 32'h40000000);
        issue(1, 32'h3F000000, 32'h3F000000);
        wait_got(2, "pair_done");
        expect_grant(1, "pair_first"); expect_grant(3, "pair_second");
        expect_resp(1, 32'h3E800000, "pair_r1"); expect_resp(3, 32'h40400000, "pair_r3");

        // result backpressure on requester 1 with requester 0 queued
        tick();
        resp_hold = 4'b0010;
        issue(1, 32'h40800000, 32'h3E800000);
        for (int k = 0; k < 200; k++) begin
            if (resp_stb[1]) break;
            tick();
        end
        check("bp_reached", 32'(resp_stb[1]), 32'd1);
        issue(0, 32'h40000000, 32'h40400000);
        repeat (10) begin
            tick();
            check("bp_stb", 32'(resp_stb), 32'h2);
            check("bp_z", resp_z, 32'h3F800000);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_no_ack", 32'(req_ack), 32'd0);
        end
        resp_hold = '0;
        wait_got(2, "bp_done");
        expect_grant(1, "bp_g1"); expect_grant(0, "bp_g0");
        expect_resp(1, 32'h3F800000, "bp_r1"); expect_resp(0, 32'h40C00000, "bp_r0");

        // reset while waiting on the product
        tick();
        issue(2, 32'h40000000, 32'h40400000);
        for (int k = 0; k < 200; k++) begin
            if (mul_z_ack) break;
            tick();
        end
        check("rw_reached", 32'(mul_z_ack), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("rw_reset");
        expect_grant(2, "rw_grant");
        repeat (20) tick();
        check("rw_no_resp", 32'(got_id.size()), 32'd0);
        issue(0, 32'h40000000, 32'h40400000);
        wait_got(1, "rw_after_done");
        expect_grant(0, "rw_after_grant");
        expect_resp(0, 32'h40C00000, "rw_after");

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
